gpu_text_engine: RTL and testbench

Parametrised text-mode command engine for the GPU: it accepts opcode/parameter pairs from the CPU side through a valid/ready handshake and maintains a cursor. It owns the character RAM, including multi-cycle clear and hardware scroll sweeps, and exposes a registered read port to the VGA text renderer. It replaces the fixed 40x25, two-word-serial command decoder with a configurable grid and explicit backpressure.

---
 rtl/gpu_text_engine.sv | 168 ++++++++++++++++
 tb/tb_gpu_text_engine.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_text_engine.sv
// Text-mode command engine: cursor, character RAM, clear/scroll sweeps, registered renderer read port.
// Optional hardware scroll on last-row advance is enabled by defining GPU_TEXT_SCROLL_EN.
`timescale 1ns/1ps
module gpu_text_engine #(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int CHAR_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_op,
  input  logic [15:0]       cmd_param,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CHAR_W-1:0] rd_data,
  output logic              busy,
  output logic [7:0]        cur_x,
  output logic [7:0]        cur_y,
  output logic              err
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_E = (ADDR_W+1)'(CELLS);
  localparam logic [7:0]        XMAX = 8'(COLS - 1);
  localparam logic [7:0]        YMAX = 8'(ROWS - 1);

`ifdef GPU_TEXT_SCROLL_EN
  localparam logic [ADDR_W-1:0] COPY_LAST_A = ADDR_W'((ROWS - 1) * COLS - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL_COPY, SCROLL_FILL} state_e;
`else
  typedef enum logic {IDLE, CLEAR} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          x_q, x_d, y_q, y_d;
  logic                err_q, err_d;
  logic [CHAR_W-1:0]   rd_q;
  logic [CHAR_W-1:0]   mem_q [CELLS];
  logic                we, adv, clr_go;
  logic [ADDR_W-1:0]   waddr, ptr;
  logic [CHAR_W-1:0]   wdata;

  assign ptr       = ADDR_W'(y_q) * COLS_A + ADDR_W'(x_q);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign cur_x     = x_q;
  assign cur_y     = y_q;
  assign err       = err_q;
  assign rd_data   = rd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = 1'b0;
    we      = 1'b0;
    waddr   = ptr;
    wdata   = '0;
    adv     = 1'b0;
    clr_go  = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        case (cmd_op)
          8'hC0: if (cmd_param == 16'd0) clr_go = 1'b1; else err_d = 1'b1;
          8'hC1: begin
            we    = 1'b1;
            wdata = cmd_param[CHAR_W-1:0];
            if (x_q < XMAX) x_d = x_q + 8'd1;
            else begin
              x_d = '0;
              adv = 1'b1;
            end
          end
          8'hC2: begin
            // Both the in-row and row-wrap cases land on the cell just before ptr.
            waddr = ptr - ADDR_W'(1);
            if (x_q != 8'd0) begin
              x_d = x_q - 8'd1;
              we  = 1'b1;
            end else if (y_q != 8'd0) begin
              x_d = XMAX;
              y_d = y_q - 8'd1;
              we  = 1'b1;
            end
          end
          8'hC3: if (cmd_param < 16'(ROWS)) y_d = cmd_param[7:0]; else err_d = 1'b1;
          8'hC4: if (cmd_param < 16'(COLS)) x_d = cmd_param[7:0]; else err_d = 1'b1;
          8'hC5: clr_go = 1'b1;
          8'hC6: begin
            x_d = '0;
            adv = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
        if (clr_go) begin
          state_d = CLEAR;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end
        if (adv) begin
          if (y_q < YMAX) y_d = y_q + 8'd1;
          else begin
`ifdef GPU_TEXT_SCROLL_EN
            state_d = (ROWS > 1) ? SCROLL_COPY : SCROLL_FILL;
            cnt_d   = '0;
`else
            y_d = '0;
`endif
          end
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_A) state_d = IDLE;
      end
`ifdef GPU_TEXT_SCROLL_EN
      SCROLL_COPY: begin
        // Private read port: the renderer port stays untouched during the sweep.
        we    = 1'b1;
        waddr = cnt_q;
        wdata = mem_q[cnt_q + COLS_A];
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == COPY_LAST_A) state_d = SCROLL_FILL;
      end
      SCROLL_FILL: begin
        we    = 1'b1;
        waddr = cnt_q;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_A) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // RAM is never reset; a clr mid-sweep just stops further writes.
  always_ff @(posedge clk) begin
    if (we && !clr) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      rd_q    <= ({1'b0, rd_addr} < CELLS_E) ? mem_q[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_gpu_text_engine.sv
// Self-checking bench for gpu_text_engine at 40x25: vector table, corner sequences, random vs array model.
`timescale 1ns/1ps
module tb_gpu_text_engine;
  localparam int COLS  = 40;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          clr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_op;
  logic [15:0]   cmd_param;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic [7:0]    cur_x, cur_y;
  logic          err;

  gpu_text_engine #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(8), .ADDR_W(AW)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_param(cmd_param), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .cur_x(cur_x), .cur_y(cur_y), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] mdl [CELLS];
  int mx = 0, my = 0;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] p;
    int          ex, ey;
    logic        eerr;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < CELLS; a++) mdl[a] = 8'h00;
    mx = 0;
    my = 0;
  endtask

  task automatic model_adv(output bit sw);
    sw = 0;
    if (my < ROWS - 1) my++;
    else begin
`ifdef GPU_TEXT_SCROLL_EN
      for (int a = 0; a < CELLS - COLS; a++) mdl[a] = mdl[a + COLS];
      for (int a = CELLS - COLS; a < CELLS; a++) mdl[a] = 8'h00;
      sw = 1;
`else
      my = 0;
`endif
    end
  endtask

  task automatic model_cmd(input logic [7:0] op, input logic [15:0] p, output bit e, output bit sw);
    e = 0;
    sw = 0;
    case (op)
      8'hC0: if (p == 0) begin model_clear(); sw = 1; end else e = 1;
      8'hC1: begin
        mdl[my*COLS + mx] = p[7:0];
        if (mx < COLS - 1) mx++;
        else begin mx = 0; model_adv(sw); end
      end
      8'hC2: begin
        if (mx > 0) begin mx--; mdl[my*COLS + mx] = 8'h00; end
        else if (my > 0) begin mx = COLS - 1; my--; mdl[my*COLS + mx] = 8'h00; end
      end
      8'hC3: if (p < ROWS) my = int'(p); else e = 1;
      8'hC4: if (p < COLS) mx = int'(p); else e = 1;
      8'hC5: begin model_clear(); sw = 1; end
      8'hC6: begin mx = 0; model_adv(sw); end
      default: e = 1;
    endcase
  endtask

  // Called at a falling edge with cmd_ready high; returns at the falling edge after acceptance.
  task automatic cmd(input logic [7:0] op, input logic [15:0] p);
    cmd_op = op;
    cmd_param = p;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_busy(output int n, output int rdy_hi);
    n = 0;
    rdy_hi = 0;
    while (busy && n < 3000) begin
      if (cmd_ready) rdy_hi++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [15:0] p);
    bit e, sw;
    int n, rh;
    model_cmd(op, p, e, sw);
    cmd(op, p);
    check($sformatf("err op%0h", op), err, e);
    if (sw) begin
      wait_busy(n, rh);
      check($sformatf("sweep_len op%0h", op), n, CELLS);
      check("ready_in_sweep", rh, 0);
    end else check($sformatf("busy op%0h", op), busy, 0);
    check($sformatf("cur_x op%0h", op), cur_x, mx);
    check($sformatf("cur_y op%0h", op), cur_y, my);
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    rd_addr = AW'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic compare_ram(input string nm);
    int bad, first;
    logic [7:0] d;
    bad = 0;
    first = -1;
    for (int a = 0; a < CELLS; a++) begin
      rd(a, d);
      if (d !== mdl[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    if (bad != 0) $display("first bad cell %0d", first);
    check(nm, bad, 0);
  endtask

  task automatic fill();
    bit e, sw;
    run_cmd(8'hC3, 16'd0);
    run_cmd(8'hC4, 16'd0);
    for (int i = 0; i < CELLS - 1; i++) begin
      logic [15:0] ch;
      ch = 16'($urandom_range(1, 255));
      model_cmd(8'hC1, ch, e, sw);
      cmd(8'hC1, ch);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n, rh;
    clr = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 8'h00;
    cmd_param = 16'h0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst rd_data", rd_data, 0);
    check("rst busy", busy, 0);
    check("rst ready", cmd_ready, 1);
    check("rst cur_x", cur_x, 0);
    check("rst cur_y", cur_y, 0);
    check("rst err", err, 0);
    clr = 1'b0;
    @(negedge clk);
    run_cmd(8'hC5, 16'd0);

    tbl[0]  = '{8'hC1, 16'h41,  1,  0, 1'b0};
    tbl[1]  = '{8'hC4, 16'd39, 39,  0, 1'b0};
    tbl[2]  = '{8'hC3, 16'd0,  39,  0, 1'b0};
    tbl[3]  = '{8'hC1, 16'h42,  0,  1, 1'b0};
    tbl[4]  = '{8'hC3, 16'd25,  0,  1, 1'b1};
    tbl[5]  = '{8'hC2, 16'd0,  39,  0, 1'b0};
    tbl[6]  = '{8'hC4, 16'd0,   0,  0, 1'b0};
    tbl[7]  = '{8'hC2, 16'd0,   0,  0, 1'b0};
    tbl[8]  = '{8'hC4, 16'd40,  0,  0, 1'b1};
    tbl[9]  = '{8'hC9, 16'd0,   0,  0, 1'b1};
    tbl[10] = '{8'h00, 16'd0,   0,  0, 1'b1};
    tbl[11] = '{8'hC0, 16'd1,   0,  0, 1'b1};
    tbl[12] = '{8'hC6, 16'd0,   0,  1, 1'b0};
    tbl[13] = '{8'hC3, 16'd24,  0, 24, 1'b0};
    tbl[14] = '{8'hC4, 16'd255, 0, 24, 1'b1};
    for (int i = 0; i < 15; i++) begin
      bit e, sw;
      model_cmd(tbl[i].op, tbl[i].p, e, sw);
      cmd(tbl[i].op, tbl[i].p);
      check($sformatf("vec%0d err", i), err, tbl[i].eerr);
      check($sformatf("vec%0d x", i), cur_x, tbl[i].ex);
      check($sformatf("vec%0d y", i), cur_y, tbl[i].ey);
      check($sformatf("vec%0d busy", i), busy, 0);
    end
    rd(0, d);    check("cell0", d, 8'h41);
    rd(39, d);   check("cell39 bs", d, 8'h00);
    rd(1000, d); check("rd oob 1000", d, 8'h00);
    rd(4095, d); check("rd oob 4095", d, 8'h00);

    // Write and read of the same cell on one edge returns the old value first.
    rd_addr = AW'(960);
    run_cmd(8'hC1, 16'h5A);
    check("same_edge old", rd_data, 8'h00);
    @(negedge clk);
    check("same_edge new", rd_data, 8'h5A);

    // Clear with a command held during the sweep; it lands on the first ready edge.
    fill();
    begin
      bit e, sw;
      model_cmd(8'hC5, 16'd0, e, sw);
    end
    cmd(8'hC5, 16'd0);
    check("clr x0", cur_x, 0);
    cmd_op = 8'hC4; cmd_param = 16'd7; cmd_valid = 1'b1;
    n = 0; rh = 0;
    while (busy && n < 3000) begin
      if (cmd_ready) rh++;
      if (n == 500) check("held ignored", cur_x, 0);
      n++;
      @(negedge clk);
    end
    check("clear len", n, CELLS);
    check("clear ready low", rh, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    begin
      bit e, sw;
      model_cmd(8'hC4, 16'd7, e, sw);
    end
    check("held accepted", cur_x, 7);
    compare_ram("ram after clear");

    // clr in the middle of a clear sweep.
    fill();
    cmd(8'hC5, 16'd0);
    for (int a = 0; a < 500; a++) mdl[a] = 8'h00;
    mx = 0; my = 0;
    rd_addr = AW'(600);
    repeat (500) @(negedge clk);
    check("mid busy", busy, 1);
    clr = 1'b1;
    @(negedge clk);
    check("midclr busy", busy, 0);
    check("midclr ready", cmd_ready, 1);
    check("midclr rd_data", rd_data, 0);
    check("midclr x", cur_x, 0);
    check("midclr y", cur_y, 0);
    check("midclr err", err, 0);
    clr = 1'b0;
    @(negedge clk);
    check("cell600 kept", rd_data, mdl[600]);
    compare_ram("ram partial clear");

    // Put at the last cell: scroll or wrap depending on build.
    run_cmd(8'hC3, 16'd24);
    run_cmd(8'hC4, 16'd39);
    run_cmd(8'hC1, 16'h44);
`ifdef GPU_TEXT_SCROLL_EN
    check("scroll x", cur_x, 0);
    check("scroll y", cur_y, 24);
    rd(959, d); check("scroll cell959", d, 8'h44);
    rd(999, d); check("scroll cell999", d, 8'h00);
`else
    check("wrap x", cur_x, 0);
    check("wrap y", cur_y, 0);
    rd(999, d); check("wrap cell999", d, 8'h44);
`endif
    compare_ram("ram after last put");

    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] op;
      logic [15:0] p;
      r = $urandom_range(0, 99);
      p = 16'($urandom_range(0, 255));
      if (r < 30)      op = 8'hC1;
      else if (r < 45) op = 8'hC2;
      else if (r < 58) begin op = 8'hC3; p = 16'($urandom_range(0, 30)); end
      else if (r < 71) begin op = 8'hC4; p = 16'($urandom_range(0, 45)); end
      else if (r < 81) op = 8'hC6;
      else if (r < 83) op = 8'hC5;
      else if (r < 86) begin op = 8'hC0; p = 16'($urandom_range(0, 3)); end
      else             op = 8'($urandom_range(0, 255));
      run_cmd(op, p);
      if ((i % 7) == 0) begin
        int a;
        a = $urandom_range(0, 1100);
        rd(a, d);
        check($sformatf("rand rd %0d", a), d, (a < CELLS) ? mdl[a] : 8'h00);
      end
      if ((i % 100) == 99) compare_ram("ram random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
